scan_mux: RTL and testbench

Time-multiplexed reader for the five 4-bit digit slots written by the one-hot-addressed switch demultiplexer in the watch datapath. It cycles through slots 0 to 4 at a prescaled rate. For each slot it drives the slot address, using the same encoding the demultiplexer consumes, and presents that slot's value on a single 4-bit output for the display driver. It also flags frame boundaries so downstream logic can latch a consistent set of digits.

---
 rtl/scan_pkg.sv | 36 +++
 rtl/scan_prescaler.sv | 26 ++
 rtl/scan_mux.sv | 102 ++++++++++
 tb/tb_scan_mux.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared slot definitions for the digit-slot demultiplexer and the scan reader.
// Slot addresses: slot 0 is all-zero, slots 1..4 are one-hot.
package scan_pkg;

  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned SLOT_W    = 4;

  localparam logic [SLOT_W-1:0] ADR_S0 = 4'b0000;
  localparam logic [SLOT_W-1:0] ADR_S1 = 4'b0001;
  localparam logic [SLOT_W-1:0] ADR_S2 = 4'b0010;
  localparam logic [SLOT_W-1:0] ADR_S3 = 4'b0100;
  localparam logic [SLOT_W-1:0] ADR_S4 = 4'b1000;

  typedef enum logic [2:0] {
    SLOT0 = 3'd0,
    SLOT1 = 3'd1,
    SLOT2 = 3'd2,
    SLOT3 = 3'd3,
    SLOT4 = 3'd4
  } slot_t;

  function automatic logic [SLOT_W-1:0] slot_adr(input slot_t s);
    logic [SLOT_W-1:0] a;
    a = ADR_S0;
    unique case (s)
      SLOT0:   a = ADR_S0;
      SLOT1:   a = ADR_S1;
      SLOT2:   a = ADR_S2;
      SLOT3:   a = ADR_S3;
      SLOT4:   a = ADR_S4;
      default: a = ADR_S0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot dwell prescaler: pulses tick on the last enabled cycle of every DIV-cycle period.
module scan_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Time-multiplexed reader for the five digit slots, with frame-boundary pulse.
// Optional anti-ghosting blank cycle on each slot change: define SCAN_MUX_BLANK_EN.
module scan_mux
  import scan_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [SLOT_W-1:0] in0,
  input  logic [SLOT_W-1:0] in1,
  input  logic [SLOT_W-1:0] in2,
  input  logic [SLOT_W-1:0] in3,
  input  logic [SLOT_W-1:0] in4,
  output logic [SLOT_W-1:0] adress,
  output logic [SLOT_W-1:0] out,
  output logic              frame_done,
  output logic              blank
);

  slot_t             slot, slot_d;
  logic              tick;
  logic [SLOT_W-1:0] sel;

  scan_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= SLOT0;
    end else begin
      slot <= slot_d;
    end
  end

  always_comb begin
    slot_d = slot;
    if (tick) begin
      unique case (slot)
        SLOT0:   slot_d = SLOT1;
        SLOT1:   slot_d = SLOT2;
        SLOT2:   slot_d = SLOT3;
        SLOT3:   slot_d = SLOT4;
        SLOT4:   slot_d = SLOT0;
        default: slot_d = SLOT0;
      endcase
    end
  end

  // Selecting on the next-state slot lets out and adress change on the same edge.
  always_comb begin
    sel = '0;
    unique case (slot_d)
      SLOT0:   sel = in0;
      SLOT1:   sel = in1;
      SLOT2:   sel = in2;
      SLOT3:   sel = in3;
      SLOT4:   sel = in4;
      default: sel = '0;
    endcase
  end

  assign adress = slot_adr(slot);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (slot == SLOT4);
    end
  end

`ifdef SCAN_MUX_BLANK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      blank <= 1'b0;
    end else if (en) begin
      blank <= tick;
      out   <= tick ? '0 : sel;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else if (en) begin
      out <= sel;
    end
  end

  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux at DIV=4 and DIV=1 against an enabled-cycle-count model.
module tb_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0, in4 = '0;

  logic [3:0] a4, o4, a1, o1;
  logic       fd4, b4, fd1, b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scan_mux #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .adress(a4), .out(o4), .frame_done(fd4), .blank(b4)
  );

  scan_mux #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .adress(a1), .out(o1), .frame_done(fd1), .blank(b1)
  );

  // Reference model: everything derives from the number of enabled edges since reset.
  int         e4 = 0, e1 = 0;
  int         m4_slot = 0, m1_slot = 0;
  logic [3:0] m4_out = '0, m1_out = '0;
  logic       m4_fd = 1'b0, m1_fd = 1'b0, m4_bl = 1'b0, m1_bl = 1'b0;

  function automatic logic [3:0] in_of(input int s);
    case (s)
      0: return in0;
      1: return in1;
      2: return in2;
      3: return in3;
      default: return in4;
    endcase
  endfunction

  function automatic logic [3:0] exp_adr(input int s);
    logic [3:0] r;
    r = (s == 0) ? 4'b0000 : 4'(1 << (s - 1));
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      e4 = 0; e1 = 0; m4_slot = 0; m1_slot = 0;
      m4_out = '0; m1_out = '0; m4_fd = 0; m1_fd = 0; m4_bl = 0; m1_bl = 0;
    end else if (en) begin
      e4++; e1++;
      m4_slot = (e4 / 4) % 5;
      m1_slot = e1 % 5;
      m4_fd = (e4 % 20 == 0);
      m1_fd = (e1 % 5 == 0);
`ifdef SCAN_MUX_BLANK_EN
      m4_bl = (e4 % 4 == 0);
      m1_bl = 1'b1;
      m4_out = m4_bl ? 4'b0000 : in_of(m4_slot);
      m1_out = 4'b0000;
`else
      m4_out = in_of(m4_slot);
      m1_out = in_of(m1_slot);
`endif
    end else begin
      m4_fd = 0; m1_fd = 0;
    end
  end

  task automatic test_reset();
    rst_n = 0; en = 1;
    in0 = 4'd1; in1 = 4'd2; in2 = 4'd3; in3 = 4'd4; in4 = 4'd5;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (a4 !== 4'b0000) begin errors++; $display("FAIL reset_adr4 got=%b exp=0000", a4); end
    checks++; if (o4 !== 4'b0000) begin errors++; $display("FAIL reset_out4 got=%b exp=0000", o4); end
    checks++; if (fd4 !== 1'b0) begin errors++; $display("FAIL reset_fd4 got=%b exp=0", fd4); end
    checks++; if (b4 !== 1'b0) begin errors++; $display("FAIL reset_blank4 got=%b exp=0", b4); end
    checks++; if (a1 !== 4'b0000 || o1 !== 4'b0000 || fd1 !== 1'b0) begin
      errors++; $display("FAIL reset_div1 got adr=%b out=%b fd=%b exp 0000/0000/0", a1, o1, fd1);
    end
    rst_n = 1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      checks++; if (a4 !== exp_adr(m4_slot) || o4 !== m4_out || fd4 !== m4_fd) begin
        errors++; $display("FAIL frame edge=%0d got adr=%b out=%h fd=%b exp adr=%b out=%h fd=%b",
                           k, a4, o4, fd4, exp_adr(m4_slot), m4_out, m4_fd);
      end
      if (k == 3) begin checks++; if (a4 !== 4'b0000) begin errors++; $display("FAIL edge3_adr got=%b exp=0000", a4); end end
      if (k == 4) begin checks++; if (a4 !== 4'b0001) begin errors++; $display("FAIL edge4_adr got=%b exp=0001", a4); end end
      if (k == 16) begin checks++; if (a4 !== 4'b1000) begin errors++; $display("FAIL edge16_adr got=%b exp=1000", a4); end end
      if (k == 20) begin checks++; if (a4 !== 4'b0000 || fd4 !== 1'b1) begin
        errors++; $display("FAIL edge20_wrap got adr=%b fd=%b exp 0000/1", a4, fd4); end end
      if (k == 21) begin checks++; if (fd4 !== 1'b0) begin errors++; $display("FAIL edge21_fd got=%b exp=0", fd4); end end
`ifndef SCAN_MUX_BLANK_EN
      if (k == 1) begin checks++; if (o4 !== 4'd1) begin errors++; $display("FAIL edge1_out got=%0d exp=1", o4); end end
      if (k == 4) begin checks++; if (o4 !== 4'd2) begin errors++; $display("FAIL edge4_out got=%0d exp=2", o4); end end
      if (k == 16) begin checks++; if (o4 !== 4'd5) begin errors++; $display("FAIL edge16_out got=%0d exp=5", o4); end end
      if (k == 20) begin checks++; if (o4 !== 4'd1) begin errors++; $display("FAIL edge20_out got=%0d exp=1", o4); end end
`endif
    end
  endtask

  task automatic test_stall();
    int n;
    int dwell;
    logic [3:0] held;
    n = 0;
    while (a4 !== 4'b0010 && n < 100) begin @(negedge clk); n++; end
    checks++; if (a4 !== 4'b0010) begin errors++; $display("FAIL stall_wait got adr=%b exp=0010", a4); return; end
    dwell = 1;
    @(negedge clk);
    if (a4 === 4'b0010) dwell++;
    held = o4;
    en = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a4 === 4'b0010) dwell++;
      checks++; if (a4 !== 4'b0010 || o4 !== held || fd4 !== 1'b0) begin
        errors++; $display("FAIL stall_hold got adr=%b out=%h fd=%b exp 0010/%h/0", a4, o4, fd4, held);
      end
    end
    en = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a4 === 4'b0010) dwell++;
      else break;
    end
    checks++; if (dwell != 7) begin errors++; $display("FAIL stall_dwell got=%0d exp=7", dwell); end
    checks++; if (a4 !== exp_adr(m4_slot) || o4 !== m4_out) begin
      errors++; $display("FAIL stall_resume got adr=%b out=%h exp adr=%b out=%h", a4, o4, exp_adr(m4_slot), m4_out);
    end
  endtask

  task automatic test_live_update();
    int n;
    n = 0;
    while (a4 !== 4'b0010 && n < 100) begin @(negedge clk); n++; end
    checks++; if (a4 !== 4'b0010) begin errors++; $display("FAIL live_wait got adr=%b exp=0010", a4); return; end
    in2 = 4'd9;
    @(negedge clk);
    checks++; if (o4 !== 4'd9 || a4 !== 4'b0010) begin
      errors++; $display("FAIL live_update got adr=%b out=%0d exp 0010/9", a4, o4);
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    n = 0;
    while (a4 !== 4'b0100 && n < 100) begin @(negedge clk); n++; end
    checks++; if (a4 !== 4'b0100) begin errors++; $display("FAIL mrst_wait got adr=%b exp=0100", a4); return; end
    rst_n = 0;
    @(negedge clk);
    checks++; if (a4 !== 4'b0000 || o4 !== 4'b0000 || fd4 !== 1'b0 || b4 !== 1'b0) begin
      errors++; $display("FAIL mrst_state got adr=%b out=%b fd=%b blank=%b exp 0000/0000/0/0", a4, o4, fd4, b4);
    end
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (a4 === 4'b0001) break;
    end
    checks++; if (n != 4 || a4 !== 4'b0001) begin
      errors++; $display("FAIL mrst_rescan got edges=%0d adr=%b exp 4/0001", n, a4);
    end
  endtask

  task automatic test_div1();
    rst_n = 0; en = 1;
    @(negedge clk);
    rst_n = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++; if (a1 !== exp_adr(k % 5) || fd1 !== (k % 5 == 0)) begin
        errors++; $display("FAIL div1_step edge=%0d got adr=%b fd=%b exp adr=%b fd=%b",
                           k, a1, fd1, exp_adr(k % 5), (k % 5 == 0));
      end
`ifdef SCAN_MUX_BLANK_EN
      checks++; if (b1 !== 1'b1 || o1 !== 4'b0000) begin
        errors++; $display("FAIL div1_blank edge=%0d got blank=%b out=%b exp 1/0000", k, b1, o1);
      end
`else
      checks++; if (o1 !== in_of(k % 5) || b1 !== 1'b0) begin
        errors++; $display("FAIL div1_out edge=%0d got out=%h blank=%b exp %h/0", k, o1, b1, in_of(k % 5));
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 59) != 0);
      in0 = 4'($urandom); in1 = 4'($urandom); in2 = 4'($urandom);
      in3 = 4'($urandom); in4 = 4'($urandom);
      @(negedge clk);
      checks++; if (a4 !== exp_adr(m4_slot) || o4 !== m4_out || fd4 !== m4_fd || b4 !== m4_bl) begin
        errors++; $display("FAIL rand4 cyc=%0d got adr=%b out=%h fd=%b bl=%b exp adr=%b out=%h fd=%b bl=%b",
                           i, a4, o4, fd4, b4, exp_adr(m4_slot), m4_out, m4_fd, m4_bl);
      end
      checks++; if (a1 !== exp_adr(m1_slot) || o1 !== m1_out || fd1 !== m1_fd || b1 !== m1_bl) begin
        errors++; $display("FAIL rand1 cyc=%0d got adr=%b out=%h fd=%b bl=%b exp adr=%b out=%h fd=%b bl=%b",
                           i, a1, o1, fd1, b1, exp_adr(m1_slot), m1_out, m1_fd, m1_bl);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall();
    test_live_update();
    test_midframe_reset();
    test_div1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
